// File: rtl/cpu_run_checker.sv
// Run-control and result checker for the single-cycle core: holds the core in reset,
// detects the jal-x0 self-loop halt, then compares probed registers one channel per cycle.
module cpu_run_checker #(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 6,
  parameter int RESET_CYCLES   = 2,
  parameter int HALT_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int IW            = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [XLEN-1:0]          pc,
  input  logic [NUM_REGS*XLEN-1:0] probe_regs,
  input  logic [NUM_REGS*XLEN-1:0] expected,
  input  logic [NUM_REGS-1:0]      check_mask,
  output logic                     dut_reset,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic                     timeout,
  output logic [IW-1:0]            fail_index,
  output logic [XLEN-1:0]          fail_value,
  output logic [31:0]              cycle_count,
  output logic [2:0]               o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HOLD  = 3'd1,
    S_RUN   = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [31:0]       r_hold_cnt;
  logic [31:0]       r_stable;
  logic [XLEN-1:0]   r_pc_q;
  logic [IW-1:0]     r_chk_idx;

  logic [XLEN-1:0]   w_probe [NUM_REGS];
  logic [XLEN-1:0]   w_exp   [NUM_REGS];
  logic [31:0]       w_stable_next;
  logic              w_halt;
  logic              w_tmo;
  logic              w_mismatch;
  logic              w_last;
  logic              w_hold_end;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_unpack
    assign w_probe[g] = probe_regs[g*XLEN +: XLEN];
    assign w_exp[g]   = expected[g*XLEN +: XLEN];
  end

  // cycle_count is cleared on start, so zero in RUN marks the first RUN cycle.
  assign w_stable_next = ((r_cycle_nonzero()) && (pc == r_pc_q)) ? r_stable + 32'd1 : 32'd0;
  assign w_halt        = (w_stable_next == 32'(HALT_CYCLES));
  assign w_tmo         = ((cycle_count + 32'd1) == 32'(TIMEOUT_CYCLES));
  assign w_mismatch    = check_mask[r_chk_idx] && (w_probe[r_chk_idx] != w_exp[r_chk_idx]);
  assign w_last        = (r_chk_idx == IW'(NUM_REGS - 1));
  assign w_hold_end    = (r_hold_cnt == 32'(RESET_CYCLES - 1));

  function automatic logic r_cycle_nonzero();
    return (cycle_count != 32'd0);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_HOLD;
      S_HOLD:  if (w_hold_end) w_next_state = S_RUN;
      S_RUN: begin
        if (w_halt)     w_next_state = S_CHECK;
        else if (w_tmo) w_next_state = S_DONE;
      end
      S_CHECK: if (w_mismatch || w_last) w_next_state = S_DONE;
      S_DONE:  if (start) w_next_state = S_HOLD;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_cnt  <= '0;
      r_stable    <= '0;
      r_pc_q      <= '0;
      r_chk_idx   <= '0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      fail_index  <= '0;
      fail_value  <= '0;
      cycle_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_hold_cnt  <= '0;
            r_stable    <= '0;
            r_chk_idx   <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            fail_index  <= '0;
            fail_value  <= '0;
            cycle_count <= '0;
          end
        end
        S_HOLD: r_hold_cnt <= r_hold_cnt + 32'd1;
        S_RUN: begin
          cycle_count <= cycle_count + 32'd1;
          r_pc_q      <= pc;
          r_stable    <= w_stable_next;
          // Halt takes priority when both land on the same cycle.
          if (w_halt)     r_chk_idx <= '0;
          else if (w_tmo) timeout   <= 1'b1;
        end
        S_CHECK: begin
          if (w_mismatch) begin
            fail_index <= r_chk_idx;
            fail_value <= w_probe[r_chk_idx];
          end else if (w_last) begin
            pass <= 1'b1;
          end else begin
            r_chk_idx <= r_chk_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dut_reset   = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign busy        = (r_state == S_HOLD) || (r_state == S_RUN) || (r_state == S_CHECK);
  assign done        = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cpu_run_checker.sv
// Randomized and directed bench for cpu_run_checker against a window-based halt/check model.
module tb_cpu_run_checker;

  localparam int XLEN = 32;
  localparam int N    = 6;
  localparam int R    = 2;
  localparam int H    = 4;
  localparam int T    = 20;

  logic            clk = 1'b0;
  logic            reset, start;
  logic [XLEN-1:0] pc;
  logic [N*XLEN-1:0] probe_regs, expected;
  logic [N-1:0]    check_mask;
  logic            dut_reset, busy, done, pass, timeout;
  logic [2:0]      fail_index;
  logic [XLEN-1:0] fail_value;
  logic [31:0]     cycle_count;
  logic [2:0]      dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] pc_seq[$];
  bit mid_start;

  cpu_run_checker #(
    .XLEN(XLEN), .NUM_REGS(N), .RESET_CYCLES(R), .HALT_CYCLES(H), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .probe_regs(probe_regs), .expected(expected), .check_mask(check_mask),
    .dut_reset(dut_reset), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_index(fail_index), .fail_value(fail_value), .cycle_count(cycle_count),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // pc presented in RUN cycle c (1-based); the last value is held forever.
  function automatic logic [31:0] pc_at(input int c);
    if (c <= pc_seq.size()) return pc_seq[c-1];
    return pc_seq[pc_seq.size()-1];
  endfunction

  // Halt is declared at the first cycle ending H+1 equal consecutive pcs; 0 means timeout.
  function automatic int model_halt();
    for (int c = H + 1; c <= T; c++) begin
      bit same = 1'b1;
      for (int k = 0; k < H; k++)
        if (pc_at(c - k) != pc_at(c - k - 1)) same = 1'b0;
      if (same) return c;
    end
    return 0;
  endfunction

  function automatic int model_fail();
    for (int i = 0; i < N; i++)
      if (check_mask[i] && probe_regs[i*XLEN +: XLEN] != expected[i*XLEN +: XLEN]) return i;
    return -1;
  endfunction

  task automatic do_run();
    int hc, fi, exp_edges, edges;
    logic [31:0] held_count;
    hc = model_halt();
    fi = model_fail();
    if (hc == 0)      exp_edges = T;
    else if (fi >= 0) exp_edges = hc + fi + 1;
    else              exp_edges = hc + N;

    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_clr", {done, pass, timeout, fail_index, 26'd0}, 0);
    check("start_clr_cnt", cycle_count | fail_value, 0);
    for (int k = 0; k < R; k++) begin
      check("hold_rst", 32'(dut_reset), 1);
      step();
    end
    check("run_rst", 32'(dut_reset), 0);

    edges = 0;
    while (!done && edges < 100) begin
      pc    = pc_at(edges + 1);
      start = (mid_start && edges == 2);
      step();
      edges++;
    end
    start = 1'b0;
    check("done", 32'(done), 1);
    check("latency", 32'(edges), 32'(exp_edges));
    check("cycle_count", cycle_count, (hc == 0) ? 32'(T) : 32'(hc));
    check("timeout", 32'(timeout), (hc == 0) ? 1 : 0);
    check("pass", 32'(pass), (hc != 0 && fi < 0) ? 1 : 0);
    check("fail_index", 32'(fail_index), (hc != 0 && fi >= 0) ? 32'(fi) : 0);
    check("fail_value", fail_value,
          (hc != 0 && fi >= 0) ? probe_regs[fi*XLEN +: XLEN] : 32'd0);
    check("done_out", {busy, dut_reset}, 0);
    held_count = cycle_count;
    pc = pc + 32'd4;
    step();
    check("done_held", {done, cycle_count[30:0]}, {1'b1, held_count[30:0]});
  endtask

  task automatic set_regs_equal();
    for (int i = 0; i < N; i++) probe_regs[i*XLEN +: XLEN] = $urandom;
    expected   = probe_regs;
    check_mask = '1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pc = '0; mid_start = 1'b0;
    probe_regs = '0; expected = '0; check_mask = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_dut_reset", 32'(dut_reset), 1);
      check("rst_outs", {busy, done, pass, timeout, fail_index}, 0);
      check("rst_vals", cycle_count | fail_value, 0);
    end
    check("rst_idle", 32'(dbg_state), 0);
    reset = 1'b0;
    step();

    // Pass run: 0,4,..,20 then hold; start pulse during RUN must be ignored.
    pc_seq = {}; for (int i = 0; i < 6; i++) pc_seq.push_back(32'(4 * i));
    set_regs_equal();
    mid_start = 1'b1;
    do_run();
    mid_start = 1'b0;

    // Fail run: channel 3 reads 7 vs 9, channel 5 also wrong.
    probe_regs[3*XLEN +: XLEN] = 32'h7; expected[3*XLEN +: XLEN] = 32'h9;
    probe_regs[5*XLEN +: XLEN] = 32'h1; expected[5*XLEN +: XLEN] = 32'h2;
    do_run();
    check("fail_idx3", 32'(fail_index), 3);
    check("fail_val7", fail_value, 32'h7);

    check_mask = 6'b010111;
    do_run();
    check("mask_pass", 32'(pass), 1);

    check_mask = '0;
    do_run();

    // Timeout: pc increments forever.
    pc_seq = {}; for (int i = 0; i < T + 10; i++) pc_seq.push_back(32'(4 * i));
    do_run();
    check("tmo_flag", 32'(timeout), 1);

    // Halt completing exactly at cycle T.
    pc_seq = {}; for (int i = 0; i < T - H; i++) pc_seq.push_back(32'(4 * i));
    set_regs_equal();
    do_run();
    check("edge_no_tmo", 32'(timeout), 0);

    // Reset in the third RUN cycle.
    pc_seq = {}; for (int i = 0; i < 10; i++) pc_seq.push_back(32'(4 * i));
    start = 1'b1; step(); start = 1'b0;
    for (int k = 0; k < R; k++) step();
    for (int k = 1; k <= 2; k++) begin pc = pc_at(k); step(); end
    pc = pc_at(3); reset = 1'b1; step(); reset = 1'b0;
    check("midrst_dut_reset", 32'(dut_reset), 1);
    check("midrst_busy", {busy, done}, 0);
    check("midrst_count", cycle_count, 0);
    step();
    check("midrst_idle", 32'(busy), 0);

    // Randomized runs.
    for (int r = 0; r < 30; r++) begin
      int len;
      logic [31:0] v;
      len = $urandom_range(1, 19);
      v   = $urandom & 32'hFFFF_FFFC;
      pc_seq = {};
      for (int i = 0; i < len; i++) begin
        pc_seq.push_back(v);
        if ($urandom_range(0, 3) != 0) v = v + 32'd4;
      end
      for (int i = 0; i < N; i++) probe_regs[i*XLEN +: XLEN] = $urandom;
      expected = probe_regs;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 4) == 0) expected[i*XLEN +: XLEN] = ~probe_regs[i*XLEN +: XLEN];
      check_mask = N'($urandom);
      do_run();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_checker.md
# cpu_run_checker

Synthesizable run-control and result-checking harness for the single-cycle RISC-V core. It drives the core's reset for a programmed number of cycles, lets the program run, and detects program end as a PC that stops changing (a `jal x0,0` self-loop). It then compares a parametrised set of probed architectural registers against expected values, one per cycle. It reports pass, fail (with the first failing channel and its value) or timeout. It replaces fixed-delay reset and fixed-time finish in benches, and can be placed on FPGA next to the core with results routed to LEDs or UART.

## Interface
Parameters:
- `XLEN`, 32, width of PC and each probed register.
- `NUM_REGS`, 6, number of probed register channels (≥1).
- `RESET_CYCLES`, 2, cycles `dut_reset` is held after `start` (≥1).
- `HALT_CYCLES`, 4, consecutive unchanged-PC cycles that declare a halt (≥1).
- `TIMEOUT_CYCLES`, 1000, maximum RUN cycles before timeout (≥1).

Ports (`IW` = max(1, $clog2(NUM_REGS))):
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to IDLE with all outputs at reset values.
- `start`  in  1  begin a run; sampled only in IDLE or DONE.
- `pc`  in  XLEN  core PC (`pc_out`).
- `probe_regs`  in  NUM_REGS*XLEN  channel i at `[i*XLEN +: XLEN]`.
- `expected`  in  NUM_REGS*XLEN  expected values, same packing; must be held stable during CHECK.
- `check_mask`  in  NUM_REGS  bit i=1 enables comparison of channel i.
- `dut_reset`  out  1  reset to the core.
- `busy`  out  1  high in HOLD, RUN and CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  valid when `done`.
- `timeout`  out  1  valid when `done`.
- `fail_index`  out  IW  first mismatching channel.
- `fail_value`  out  XLEN  probed value of that channel.
- `cycle_count`  out  32  RUN cycles of the current or last run.

## Operation
- Reset values: `dut_reset`=1; `busy`, `done`, `pass` and `timeout`=0; `fail_index`, `fail_value` and `cycle_count`=0. State is IDLE.
- **IDLE**: `dut_reset`=1. On `start`, clear all result outputs and counters and go to HOLD.
- **HOLD**: `dut_reset`=1 for exactly RESET_CYCLES cycles, then go to RUN.
- **RUN**: `dut_reset`=0.
  - `cycle_count` increments once per RUN cycle.
  - `pc_q` captures `pc` every cycle. In the first RUN cycle the stable counter is forced to 0.
  - In later cycles: if `pc`==`pc_q`, the stable counter increments; otherwise it clears.
  - **Halt**: the stable counter reaches HALT_CYCLES. Go to CHECK with channel index 0.
  - **Timeout**: `cycle_count` reaches TIMEOUT_CYCLES without a halt. Go to DONE with `timeout`=1 and `pass`=0.
  - If halt and timeout occur in the same cycle, halt wins.
- **CHECK**: `dut_reset` stays 0 (the core spins in its halt loop). One channel i is compared per cycle, i=0..NUM_REGS-1.
  - A channel is a mismatch if `check_mask[i]`=1 and its `probe_regs` field ≠ its `expected` field.
  - First mismatch: go to DONE with `pass`=0, `fail_index`=i, `fail_value`=probed value.
  - Channel NUM_REGS-1 compared with no mismatch: go to DONE with `pass`=1.
  - All-zero `check_mask`: pass after NUM_REGS cycles.
- **DONE**: `done`=1. All results are held and `dut_reset`=0. `start` begins a new run by going to HOLD, which clears the results.
- `start` is ignored in HOLD, RUN and CHECK.
- `reset` in any state, mid-run included, returns to IDLE at that edge and re-asserts `dut_reset`.
- `cycle_count` freezes outside RUN; TIMEOUT_CYCLES bounds it, so it never wraps.

## Timing
- Outputs are registered and change only on rising edges.
- `start` sampled at edge E. HOLD occupies edges E+1..E+RESET_CYCLES, and `dut_reset` falls after edge E+RESET_CYCLES.
- Halt latency: if `pc` is constant from RUN cycle k on, CHECK is entered HALT_CYCLES cycles after k.
- CHECK lasts j+1 cycles for a failure at channel j, and NUM_REGS cycles on a pass.
- On timeout, `done` rises with `cycle_count`=TIMEOUT_CYCLES.

## Test plan
- **Reset**: hold `reset`=1 for 3 cycles, then `start` with RESET_CYCLES=2 → `dut_reset` stays 1 for exactly 2 cycles after the `start` edge, then 0. All other outputs stay 0 throughout reset.
- **Pass run**: `pc` steps 0,4,8,…,20, then holds at 20; all masked channels equal `expected`. Required: `done`=1, `pass`=1, `cycle_count`=10 (6 stepping cycles plus HALT_CYCLES=4), and DONE reached after 6 CHECK cycles.
- **Fail run**: channel 3 (r4) reads 0x7 with expected 0x9, and channel 5 also mismatches. Required: `pass`=0, `fail_index`=3, `fail_value`=0x7.
- **Masking**: the same mismatches with `check_mask`=6'b010111 → `pass`=1.
- **Timeout**: TIMEOUT_CYCLES=20 with `pc` incrementing forever → `done`=1, `timeout`=1, `pass`=0, `cycle_count`=20. Repeat with a halt completing exactly at cycle 20 → CHECK is entered and `timeout`=0.
- **Reset and restart**:
  - `reset` pulsed in cycle 3 of RUN → IDLE, `dut_reset`=1, `busy`=0, `cycle_count`=0.
  - `start` during RUN → no effect.
  - `start` in DONE → results clear and a new HOLD begins.
